// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory slice.
// Optional byte-strobe stores are enabled with DMEM_BYTE_STROBE_EN.
package dmem_pkg;

    localparam int WORD_W      = 64;
    localparam int OFF_W       = 3;
    localparam int STRB_W      = WORD_W / 8;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic misaligned(input logic [WORD_W-1:0] addr);
        return addr[OFF_W-1:0] != '0;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the LEGv8 load/store initiator and dmem_responder.
// WriteStrobe exists only when DMEM_BYTE_STROBE_EN is defined.
interface dmem_if;
    import dmem_pkg::*;

    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [WORD_W-1:0] Address;
    logic [WORD_W-1:0] WriteData;
    logic              RespValid;
    logic              RespReady;
    logic [WORD_W-1:0] ReadData;
    logic              RespError;
`ifdef DMEM_BYTE_STROBE_EN
    logic [STRB_W-1:0] WriteStrobe;

    modport master (
        output ReqValid, ReqWrite, Address, WriteData, WriteStrobe, RespReady,
        input  ReqReady, RespValid, ReadData, RespError
    );

    modport slave (
        input  ReqValid, ReqWrite, Address, WriteData, WriteStrobe, RespReady,
        output ReqReady, RespValid, ReadData, RespError
    );
`else
    modport master (
        output ReqValid, ReqWrite, Address, WriteData, RespReady,
        input  ReqReady, RespValid, ReadData, RespError
    );

    modport slave (
        input  ReqValid, ReqWrite, Address, WriteData, RespReady,
        output ReqReady, RespValid, ReadData, RespError
    );
`endif

endinterface

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous byte-enabled write port, combinational read port.
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked fixed-latency data memory responder for the LEGv8 load/store path.
// Define DMEM_BYTE_STROBE_EN to honour per-byte WriteStrobe on stores.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input logic  Clock,
    input logic  reset,
    dmem_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WORD_W-1:0] LIMIT = WORD_W'(DEPTH) << OFF_W;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;

    logic              accept;
    logic              req_err;
    logic [AW-1:0]     req_idx;
    logic [AW-1:0]     rd_idx;
    logic [WORD_W-1:0] rd_word;
    logic              we;
    logic [STRB_W-1:0] wstrb;

    assign bus.ReqReady  = (state_q == IDLE) & ~reset;
    assign bus.RespValid = (state_q == RESP);
    assign bus.ReadData  = rdata_q;
    assign bus.RespError = rerr_q;

    assign accept  = bus.ReqValid & bus.ReqReady;
    assign req_err = misaligned(bus.Address) | (bus.Address >= LIMIT);
    assign req_idx = bus.Address[AW+OFF_W-1:OFF_W];
    assign rd_idx  = (state_q == IDLE) ? req_idx : idx_q;
    // Stores commit at acceptance; faulting stores never touch memory.
    assign we      = accept & bus.ReqWrite & ~req_err;

`ifdef DMEM_BYTE_STROBE_EN
    assign wstrb = bus.WriteStrobe;
`else
    assign wstrb = '1;
`endif

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .Clock (Clock),
        .we    (we),
        .waddr (req_idx),
        .wdata (bus.WriteData),
        .wstrb (wstrb),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d  = bus.ReqWrite;
                    err_d = req_err;
                    idx_d = req_idx;
                    cnt_d = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        rdata_d = (bus.ReqWrite | req_err) ? '0 : rd_word;
                        rerr_d  = req_err;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rdata_d = (wr_q | err_q) ? '0 : rd_word;
                    rerr_d  = err_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.RespReady) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a transaction-level memory model.
// Build with DMEM_BYTE_STROBE_EN to also exercise byte-strobe stores.
module tb_dmem_responder;

    localparam int DEPTH   = 128;
    localparam int LATENCY = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_if bus();

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .Clock (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef DMEM_BYTE_STROBE_EN
    logic [7:0] strb_drv = 8'hFF;
    assign bus.WriteStrobe = strb_drv;
`endif

    int vecs = 0;
    int errs = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction model: one outstanding request, response due LATENCY edges later.
    logic [63:0] mm [DEPTH];
    bit          m_busy  = 1'b0;
    int          m_left  = 0;
    logic [63:0] m_rdata = '0;
    bit          m_err   = 1'b0;
    bit          me;
    int          mw;
    logic [7:0]  ms;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.ReqValid) begin
                me = (bus.Address % 8 != 0) || (bus.Address >= 64'(DEPTH * 8));
                mw = int'(bus.Address / 8);
`ifdef DMEM_BYTE_STROBE_EN
                ms = bus.WriteStrobe;
`else
                ms = 8'hFF;
`endif
                m_busy  = 1'b1;
                m_left  = LATENCY;
                m_err   = me;
                m_rdata = '0;
                if (!me) begin
                    if (bus.ReqWrite) begin
                        for (int b = 0; b < 8; b++)
                            if (ms[b]) mm[mw][8*b +: 8] = bus.WriteData[8*b +: 8];
                    end else begin
                        m_rdata = mm[mw];
                    end
                end
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (bus.RespReady) begin
            m_busy = 1'b0;
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            check("cmp ReqReady", bus.ReqReady, !reset && !m_busy);
            check("cmp RespValid", bus.RespValid, m_busy && m_left == 0);
            if (m_busy && m_left == 0) begin
                check("cmp ReadData", bus.ReadData, m_rdata);
                check("cmp RespError", bus.RespError, m_err);
            end
        end
    end

    task automatic req(input bit wr, input logic [63:0] addr,
                       input logic [63:0] data, input int stall,
                       output logic [63:0] rd, output bit er, output int lat);
        int n;
        @(negedge clk);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = wr;
        bus.Address   = addr;
        bus.WriteData = data;
        bus.RespReady = (stall == 0);
        n = 0;
        while (!bus.ReqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", bus.ReqReady, 1'b1);
        @(negedge clk);
        // Keep presenting a different store: it must be ignored while busy.
        bus.ReqWrite  = 1'b1;
        bus.Address   = addr ^ 64'h8;
        bus.WriteData = ~data;
        lat = 0;
        while (!bus.RespValid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("resp arrives", bus.RespValid, 1'b1);
        bus.ReqValid = 1'b0;
        rd = bus.ReadData;
        er = bus.RespError;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold RespValid", bus.RespValid, 1'b1);
            check("hold ReadData", bus.ReadData, rd);
            check("hold ReqReady", bus.ReqReady, 1'b0);
        end
        bus.RespReady = 1'b1;
        @(negedge clk);
        bus.RespReady = 1'b0;
    endtask

    logic [63:0] rd;
    bit          er;
    int          lat;

    initial begin
        reset         = 1'b1;
        bus.ReqValid  = 1'b0;
        bus.ReqWrite  = 1'b0;
        bus.Address   = '0;
        bus.WriteData = '0;
        bus.RespReady = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ReqReady", bus.ReqReady, 1'b0);
        check("reset RespValid", bus.RespValid, 1'b0);
        check("reset ReadData", bus.ReadData, 64'h0);
        check("reset RespError", bus.RespError, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("ready after reset", bus.ReqReady, 1'b1);

        req(1'b1, 64'h40, 64'h0123456789ABCDEF, 0, rd, er, lat);
        check("store latency", 64'(lat), 64'd2);
        check("store err", er, 1'b0);
        check("store rdata", rd, 64'h0);

        req(1'b0, 64'h40, 64'h0, 0, rd, er, lat);
        check("load 0x40", rd, 64'h0123456789ABCDEF);
        check("load err", er, 1'b0);
        check("load latency", 64'(lat), 64'd2);

        req(1'b1, 64'h43, 64'hFFFF, 0, rd, er, lat);
        check("misaligned store err", er, 1'b1);
        check("misaligned store rdata", rd, 64'h0);
        req(1'b0, 64'h40, 64'h0, 0, rd, er, lat);
        check("0x40 unchanged", rd, 64'h0123456789ABCDEF);

        req(1'b0, 64'h400, 64'h0, 0, rd, er, lat);
        check("oor load err", er, 1'b1);
        check("oor load rdata", rd, 64'h0);

        req(1'b1, 64'h3F8, 64'hCAFEF00D12345678, 0, rd, er, lat);
        check("last word store err", er, 1'b0);
        req(1'b0, 64'h3F8, 64'h0, 0, rd, er, lat);
        check("last word load", rd, 64'hCAFEF00D12345678);

        req(1'b0, 64'h8000_0000_0000_0040, 64'h0, 0, rd, er, lat);
        check("high addr err", er, 1'b1);
        check("high addr rdata", rd, 64'h0);
        req(1'b0, 64'h3FC, 64'h0, 0, rd, er, lat);
        check("misaligned load err", er, 1'b1);

        req(1'b0, 64'h40, 64'h0, 5, rd, er, lat);
        check("backpressure data", rd, 64'h0123456789ABCDEF);
        check("idle after release", bus.ReqReady, 1'b1);

        @(negedge clk);
        reset         = 1'b1;
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = 1'b1;
        bus.Address   = 64'h40;
        bus.WriteData = 64'hDEAD;
        repeat (2) @(negedge clk);
        bus.ReqValid = 1'b0;
        reset        = 1'b0;
        req(1'b0, 64'h40, 64'h0, 0, rd, er, lat);
        check("no accept in reset", rd, 64'h0123456789ABCDEF);

        @(negedge clk);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = 1'b1;
        bus.Address   = 64'h08;
        bus.WriteData = 64'hAA;
        @(negedge clk);
        bus.ReqValid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no resp after reset", bus.RespValid, 1'b0);
        end
        check("ready after wait reset", bus.ReqReady, 1'b1);
        req(1'b0, 64'h08, 64'h0, 0, rd, er, lat);
        check("store kept over reset", rd, 64'hAA);

        req(1'b1, 64'h10, 64'h1111111111111111, 0, rd, er, lat);
`ifdef DMEM_BYTE_STROBE_EN
        strb_drv = 8'h0F;
        req(1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 0, rd, er, lat);
        strb_drv = 8'hFF;
        req(1'b0, 64'h10, 64'h0, 0, rd, er, lat);
        check("strobe 0x0F", rd, 64'h11111111FFFFFFFF);
        strb_drv = 8'h00;
        req(1'b1, 64'h10, 64'h2222222222222222, 0, rd, er, lat);
        check("strobe 0x00 err", er, 1'b0);
        strb_drv = 8'hA0;
        req(1'b1, 64'h10, 64'h3333333333333333, 0, rd, er, lat);
        strb_drv = 8'hFF;
        req(1'b0, 64'h10, 64'h0, 0, rd, er, lat);
        check("strobe 0xA0", rd, 64'h33113311FFFFFFFF);
`else
        req(1'b0, 64'h10, 64'h0, 0, rd, er, lat);
        check("full store 0x10", rd, 64'h1111111111111111);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
